uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
//  Serial UART transmitter; consumes o_tx_result / o_tx_signal from the INTF stage and
//  drives the TX pin. Frame: 1 start bit (0), SIZEDATA data bits LSB-first, 1 stop bit (1).
//  Bit timing comes from an external oversampling tick (i_tick) shared with the RX path.
// PARAMETERS
//  SIZEDATA    8   data bits per frame
//  OVERSAMPLE  16  i_tick pulses per start/data bit
//  SB_TICK     16  i_tick pulses for the stop bit (16 = 1 stop bit, 32 = 2 stop bits)
// PORTS
//  i_clock     in   1         system clock, all logic on posedge
//  i_reset     in   1         synchronous, active-high reset
//  i_tick      in   1         1-cycle oversample strobe from baud_rate_gen
//  i_tx_start  in   1         request to send i_tx_data (level sampled each clock)
//  i_tx_data   in   SIZEDATA  byte to send, captured on accepted start
//  o_tx        out  1         serial line, idles high
//  o_tx_busy   out  1         1 while a frame is in progress (state != IDLE)
//  o_tx_done   out  1         1-cycle pulse when a frame completes
// BEHAVIOUR
//  Reset: state=IDLE, o_tx=1, o_tx_busy=0, o_tx_done=0, tick/bit counters=0, shift reg=0.
//   Reset has priority over everything, including a frame in flight: the line returns
//   high on the next edge, no o_tx_done pulse is issued, and the partial frame is dropped.
//  FSM: IDLE -> START -> DATA -> STOP -> IDLE. All outputs are registered.
//   IDLE:  o_tx=1. If i_tx_start=1: latch i_tx_data into the shift register,
//          clear the tick counter, go to START. Otherwise stay.
//   START: o_tx=0. On each i_tick, tick_cnt++. On the tick where tick_cnt==OVERSAMPLE-1:
//          clear tick_cnt and bit_cnt, go to DATA.
//   DATA:  o_tx=shreg[0]. When tick_cnt reaches OVERSAMPLE-1: shift right, clear tick_cnt.
//          If bit_cnt==SIZEDATA-1, go to STOP; else bit_cnt++.
//   STOP:  o_tx=1. When tick_cnt reaches SB_TICK-1 on a tick: go to IDLE, o_tx_done=1 for one cycle.
//  Latency: o_tx falls on the first clock edge after i_tx_start is sampled in IDLE.
//   Frame length is exactly OVERSAMPLE*(1+SIZEDATA)+SB_TICK ticks; every bit boundary
//   is aligned to an i_tick.
//  Handshake: i_tx_start is ignored while o_tx_busy=1, and i_tx_data may change freely
//   after acceptance. A start sampled in the same cycle o_tx_done=1 (state already IDLE)
//   is accepted, which allows back-to-back frames with no idle gap beyond one clock.
//  Simultaneous i_tick and accepted start in IDLE: that tick is not counted. Counting
//   starts from the next tick, so the start bit is never short.
//  No i_tick: the FSM holds its state and o_tx holds its value indefinitely.
//  Widths: tick_cnt has enough bits for max(OVERSAMPLE,SB_TICK)-1; bit_cnt has
//   $clog2(SIZEDATA) bits. Neither counter may wrap before its compare fires.
// STRUCTURE
//  Shared include (uart_defs): FSM state encodings (2 bits: IDLE=0, START=1, DATA=2,
//   STOP=3) and the default values of SIZEDATA/OVERSAMPLE/SB_TICK, shared with uart_rx.
//  No internal sub-module. baud_rate_gen is a sibling block that drives i_tick for
//   both uart_rx and uart_tx; it is not instantiated here.
// TESTING (tick every 4 clocks => 64 clocks per bit, 640 clocks per frame)
//  1 Reset held 5 clocks, then released: o_tx=1, busy=0, done=0, and these hold
//    for 100 clocks with no start.
//  2 Start with data=0x06 (ALU result of 2+4): o_tx samples at bit centres are
//    0,0,1,1,0,0,0,0,0,1; done pulses once, 640 clocks after start.
//  3 Start pulse while busy (data=0xFF, mid-frame of 0xA5): serial stream still decodes
//    as 0xA5, with no second frame.
//  4 Start re-asserted in the done cycle with data=0x3C: next frame begins with no
//    extra idle bit and decodes as 0x3C.
//  5 Reset asserted in DATA of a 0x55 frame: o_tx=1 and busy=0 on the next edge, no done pulse;
//    a following 0x81 frame decodes correctly.
//  6 Start coincident with i_tick in IDLE: start bit lasts exactly 16 ticks (64 clocks).

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings, default frame parameters and
// a counter-width helper. Intended to be imported by both uart_tx and uart_rx.
package uart_tx_pkg;

  // Default frame shape: 8 data bits, 16 oversample ticks per bit, one stop bit.
  localparam int SIZEDATA_DEF   = 8;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int SB_TICK_DEF    = 16;

  // Two-bit state encoding shared with the receiver.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Bits needed to hold values 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// Serial UART transmitter.
// Sends 1 start bit (0), SIZEDATA data bits LSB-first, then a stop bit (1).
// Bit timing comes from the external oversample strobe i_tick: each start/data
// bit lasts OVERSAMPLE ticks and the stop bit lasts SB_TICK ticks.
//
// Ports:
//   i_clock     system clock, all logic on posedge
//   i_reset     synchronous active-high reset
//   i_tick      one-cycle oversample strobe from the baud generator
//   i_tx_start  request to send i_tx_data (level, sampled each clock in IDLE)
//   i_tx_data   byte to send, captured when a start is accepted
//   o_tx        serial line, idles high
//   o_tx_busy   high while a frame is in progress
//   o_tx_done   one-cycle pulse when a frame completes
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int SIZEDATA   = SIZEDATA_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int SB_TICK    = SB_TICK_DEF
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_tick,
  input  logic                i_tx_start,
  input  logic [SIZEDATA-1:0] i_tx_data,
  output logic                o_tx,
  output logic                o_tx_busy,
  output logic                o_tx_done
);

  // Tick counter must reach the larger of the two per-bit tick budgets.
  localparam int TW = cnt_width((OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK);
  localparam int BW = cnt_width(SIZEDATA);

  localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SIZEDATA - 1);

  tx_state_e             state_q;
  logic [TW-1:0]         tick_cnt_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [SIZEDATA-1:0]   shreg_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  done_q;

  // Shift register contents after the current bit has been sent; its LSB is
  // the next bit to drive, so the registered line stays aligned with the shift.
  logic [SIZEDATA-1:0]   shreg_next;
  assign shreg_next = shreg_q >> 1;

  // NOTE: every register here, including the shift register, is reset so the
  // line and status outputs are defined from the first clock after reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: default-low assignment ahead of the case makes done a single-cycle
      // pulse; the STOP branch overrides it only on the completing tick.
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // A tick arriving with the accepted start is deliberately not counted,
          // so the start bit always spans a full OVERSAMPLE ticks.
          if (i_tx_start) begin
            shreg_q    <= i_tx_data;
            tick_cnt_q <= '0;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          if (i_tick) begin
            if (tick_cnt_q == OS_LAST) begin
              tick_cnt_q <= '0;
              bit_cnt_q  <= '0;
              tx_q       <= shreg_q[0];
              state_q    <= ST_DATA;
            end else begin
              tick_cnt_q <= tick_cnt_q + TW'(1);
            end
          end
        end
        ST_DATA: begin
          if (i_tick) begin
            if (tick_cnt_q == OS_LAST) begin
              tick_cnt_q <= '0;
              shreg_q    <= shreg_next;
              if (bit_cnt_q == BIT_LAST) begin
                tx_q    <= 1'b1;
                state_q <= ST_STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q + BW'(1);
                tx_q      <= shreg_next[0];
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TW'(1);
            end
          end
        end
        ST_STOP: begin
          if (i_tick) begin
            if (tick_cnt_q == SB_LAST) begin
              tick_cnt_q <= '0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= ST_IDLE;
            end else begin
              tick_cnt_q <= tick_cnt_q + TW'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_tx      = tx_q;
  assign o_tx_busy = busy_q;
  assign o_tx_done = done_q;

endmodule
